// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Load/store has priority; a starvation counter forces periodic fetch grants.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  if_req_valid,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_data,
  input  logic                  i_if_flush,
  input  logic                  ls_req_valid,
  input  logic                  ls_req_we,
  input  logic [ADDR_W-1:0]     ls_req_addr,
  input  logic [DATA_W-1:0]     ls_req_wdata,
  input  logic [DATA_W/8-1:0]   ls_req_wstrb,
  output logic                  ls_req_ready,
  output logic                  ls_rsp_valid,
  output logic [DATA_W-1:0]     ls_rsp_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-3:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WADR_W = ADDR_W - 2;

  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             if_gnt;
  logic             ls_gnt;
  logic             pend;
  owner_e           owner;
  logic             is_wr;

  // Byte offsets within a word are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_req_addr[1:0], ls_req_addr[1:0]};

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Grant: LS first unless fetch is starved; flush blocks any fetch grant.
  always_comb begin
    if_gnt = i_rstn & if_req_valid & ~i_if_flush & (~ls_req_valid | starved);
    ls_gnt = i_rstn & ls_req_valid & ~if_gnt;
  end

  assign if_req_ready = if_gnt;
  assign ls_req_ready = ls_gnt;

  // Memory issue path; idle and read cycles drive zero write payload.
  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (if_gnt) begin
      mem_addr = WADR_W'(if_req_addr[ADDR_W-1:2]);
    end else if (ls_gnt) begin
      mem_addr = WADR_W'(ls_req_addr[ADDR_W-1:2]);
      if (ls_req_we) begin
        mem_we    = 1'b1;
        mem_wdata = ls_req_wdata;
        mem_wstrb = STRB_W'(ls_req_wstrb);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      starve_cnt <= '0;
      pend       <= 1'b0;
      owner      <= OWN_IF;
      is_wr      <= 1'b0;
    end else begin
      if (if_gnt || !if_req_valid) begin
        starve_cnt <= '0;
      end else if (ls_gnt && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      pend  <= if_gnt | ls_gnt;
      owner <= ls_gnt ? OWN_LS : OWN_IF;
      is_wr <= ls_gnt & ls_req_we;
    end
  end

  // Response routing one cycle after issue; a flush kills a due fetch response.
  always_comb begin
    if_rsp_valid = pend & (owner == OWN_IF) & ~i_if_flush;
    ls_rsp_valid = pend & (owner == OWN_LS);
    if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    ls_rsp_data  = (ls_rsp_valid && !is_wr) ? mem_rdata : '0;
  end

endmodule
